// File: rtl/cpu_init_pkg.sv
// Shared definitions for the CPU RAM boot loader.
//   ADDR_W : RAM / ROM address and data byte width
//   IDX_W  : byte index width (one extra bit so 256 bytes can be counted)
//   CNT_W  : shared FETCH-latency / RELEASE-hold down-counter width
package cpu_init_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned IDX_W  = 9;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_MAR     = 3'd2,
    ST_GAP     = 3'd3,
    ST_RAM     = 3'd4,
    ST_NEXT    = 3'd5,
    ST_RELEASE = 3'd6,
    ST_DONE    = 3'd7
  } boot_state_e;

endpackage

// File: rtl/ram_boot_loader.sv
// Copies PROG_LEN bytes from the program ROM into the CPU RAM through the
// CPU init port, holding the CPU in reset until the whole image is loaded.
// Ports:
//   in_clk, reset_n  : clock, async active-low reset
//   start            : load request (honoured in IDLE or DONE only)
//   rom_addr/rom_data: program ROM read port
//   loading_ram      : selects the init path into the CPU RAM
//   set_mar_init     : one-cycle MAR load pulse (addr_init)
//   set_ram_init     : one-cycle RAM write pulse (instr_from_rom)
//   cpu_reset        : active-high CPU reset, low only once loading is done
//   busy, done       : status
module ram_boot_loader
  import cpu_init_pkg::*;
#(
  parameter int unsigned PROG_LEN = 256,
  parameter int unsigned ROM_LAT  = 1,
  parameter int unsigned RST_HOLD = 2
) (
  input  logic              in_clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [ADDR_W-1:0] rom_data,
  output logic              loading_ram,
  output logic              set_mar_init,
  output logic [ADDR_W-1:0] addr_init,
  output logic              set_ram_init,
  output logic [ADDR_W-1:0] instr_from_rom,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done
);

  boot_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] instr_d;
  logic              loading_d, mar_d, ram_d, cpu_reset_d, busy_d, done_d;

  // Both ports present the current byte index; the index is itself a register.
  assign rom_addr  = idx_q[ADDR_W-1:0];
  assign addr_init = idx_q[ADDR_W-1:0];

  // Next-state, counter and output decode. Outputs are decoded from the next
  // state and registered, so they line up with the state they describe.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    instr_d = instr_from_rom;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_FETCH;
          idx_d   = '0;
          cnt_d   = CNT_W'(ROM_LAT - 1);
        end
      end
      ST_FETCH: begin
        if (cnt_q == '0) begin
          state_d = ST_MAR;
          instr_d = rom_data;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_MAR: state_d = ST_GAP;
      ST_GAP: state_d = ST_RAM;
      ST_RAM: state_d = ST_NEXT;
      ST_NEXT: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q < IDX_W'(PROG_LEN - 1)) begin
          state_d = ST_FETCH;
          cnt_d   = CNT_W'(ROM_LAT - 1);
        end else begin
          state_d = ST_RELEASE;
          cnt_d   = CNT_W'(RST_HOLD - 1);
        end
      end
      ST_RELEASE: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    loading_d   = state_d inside {ST_FETCH, ST_MAR, ST_GAP, ST_RAM, ST_NEXT};
    mar_d       = (state_d == ST_MAR);
    ram_d       = (state_d == ST_RAM);
    busy_d      = loading_d || (state_d == ST_RELEASE);
    done_d      = (state_d == ST_DONE);
    cpu_reset_d = (state_d != ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      cnt_q          <= '0;
      instr_from_rom <= '0;
      loading_ram    <= 1'b0;
      set_mar_init   <= 1'b0;
      set_ram_init   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      cpu_reset      <= 1'b1;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      instr_from_rom <= instr_d;
      loading_ram    <= loading_d;
      set_mar_init   <= mar_d;
      set_ram_init   <= ram_d;
      busy           <= busy_d;
      done           <= done_d;
      cpu_reset      <= cpu_reset_d;
    end
  end

endmodule
